// File: rtl/wb_sram_bridge_pkg.sv
// wb_sram_bridge_pkg: shared state encoding and error-flag bit positions for the SRAM-to-Wishbone bridge
package wb_sram_bridge_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;
    typedef enum logic [0:0] {IDLE = ST_IDLE, BUS = ST_BUS} state_e;
    localparam int ERR_BUS     = 0;
    localparam int ERR_TIMEOUT = 1;
endpackage

// File: rtl/sram_wb_master_bridge_if.sv
// sram_wb_master_bridge_if: SRAM-style request port, Wishbone classic master port and error status
interface sram_wb_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   sram_addr;
    logic                    sram_read_en;
    logic                    sram_write_en;
    logic [DATA_WIDTH/8-1:0] sram_byte_en;
    logic [DATA_WIDTH-1:0]   sram_write_data;
    logic                    sram_ready;
    logic [DATA_WIDTH-1:0]   sram_read_data;
    logic                    sram_read_valid;
    logic [ADDR_WIDTH-1:0]   wb_adr;
    logic [DATA_WIDTH-1:0]   wb_dat_w;
    logic [DATA_WIDTH/8-1:0] wb_sel;
    logic                    wb_we;
    logic                    wb_cyc;
    logic                    wb_stb;
    logic [DATA_WIDTH-1:0]   wb_dat_r;
    logic                    wb_ack;
    logic                    wb_err;
    logic [1:0]              err_status;
    logic                    err_clr;

    modport master (
        input  sram_addr, sram_read_en, sram_write_en, sram_byte_en, sram_write_data,
        output sram_ready, sram_read_data, sram_read_valid,
        output wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_dat_r, wb_ack, wb_err,
        output err_status,
        input  err_clr
    );

    modport slave (
        output sram_addr, sram_read_en, sram_write_en, sram_byte_en, sram_write_data,
        input  sram_ready, sram_read_data, sram_read_valid,
        input  wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_dat_r, wb_ack, wb_err,
        input  err_status,
        output err_clr
    );
endinterface

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating 16-bit bus-cycle counter flagging the last cycle allowed before abort
module wb_timeout_counter #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != 16'hFFFF)
            count <= count + 16'd1;
    end

    // count holds completed bus cycles, so the current one is the TIMEOUT-th when count == TIMEOUT-1
    assign expired = enable && count == LAST;
endmodule

// File: rtl/sram_wb_master_bridge.sv
// sram_wb_master_bridge: turns single SRAM-style read/write requests into Wishbone classic cycles with timeout
module sram_wb_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input logic clk,
    input logic rst,
    sram_wb_master_bridge_if.master bus
);
    import wb_sram_bridge_pkg::*;

    state_e                state;
    logic                  req_ok;
    logic                  in_bus;
    logic                  done;
    logic                  expired;
    logic [DATA_WIDTH-1:0] rd_next;
    logic [1:0]            err_new;

    always_comb begin
        in_bus = state == BUS;
        req_ok = state == IDLE && (bus.sram_read_en ^ bus.sram_write_en) && |bus.sram_byte_en;
        done = in_bus && (bus.wb_ack || bus.wb_err || expired);
        rd_next = bus.wb_ack && !bus.wb_err ? bus.wb_dat_r : '0;
        err_new = 2'b00;
        err_new[ERR_BUS] = in_bus && bus.wb_err;
        err_new[ERR_TIMEOUT] = in_bus && expired && !bus.wb_ack && !bus.wb_err;
    end

    assign bus.sram_ready = state == IDLE;

    wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (req_ok),
        .enable  (in_bus),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            bus.wb_adr          <= {ADDR_WIDTH{1'b0}};
            bus.wb_dat_w        <= {DATA_WIDTH{1'b0}};
            bus.wb_sel          <= {(DATA_WIDTH/8){1'b0}};
            bus.wb_we           <= 1'b0;
            bus.wb_cyc          <= 1'b0;
            bus.wb_stb          <= 1'b0;
            bus.sram_read_data  <= {DATA_WIDTH{1'b0}};
            bus.sram_read_valid <= 1'b0;
            bus.err_status      <= 2'b00;
        end else begin
            bus.sram_read_valid <= done && !bus.wb_we;
            bus.err_status      <= (bus.err_clr ? 2'b00 : bus.err_status) | err_new;
            if (req_ok) begin
                state        <= BUS;
                bus.wb_adr   <= bus.sram_addr;
                bus.wb_dat_w <= bus.sram_write_data;
                bus.wb_sel   <= bus.sram_byte_en;
                bus.wb_we    <= bus.sram_write_en;
                bus.wb_cyc   <= 1'b1;
                bus.wb_stb   <= 1'b1;
            end else if (done) begin
                state      <= IDLE;
                bus.wb_cyc <= 1'b0;
                bus.wb_stb <= 1'b0;
                if (!bus.wb_we)
                    bus.sram_read_data <= rd_next;
            end
        end
    end
endmodule

// File: tb/tb_sram_wb_master_bridge.sv
// tb_sram_wb_master_bridge: directed and randomized checks of the bridge against a transaction-level model
module tb_sram_wb_master_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sram_wb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sram_wb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model: one outstanding transaction, its age in bus cycles, and the observable results
    bit          m_busy;
    int          m_age;
    logic [31:0] m_adr, m_dat, m_rdata;
    logic [3:0]  m_sel;
    bit          m_we, m_rvalid;
    logic [1:0]  m_err, m_new;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_age = 0; m_rvalid = 0; m_rdata = '0; m_err = 2'b00;
        end else begin
            m_new = 2'b00;
            m_rvalid = 0;
            if (!m_busy) begin
                if ((bus.sram_read_en != bus.sram_write_en) && bus.sram_byte_en != 4'h0) begin
                    m_busy = 1; m_age = 0; m_adr = bus.sram_addr; m_dat = bus.sram_write_data;
                    m_sel = bus.sram_byte_en; m_we = bus.sram_write_en;
                end
            end else begin
                m_age = m_age + 1;
                if (bus.wb_ack || bus.wb_err || m_age == TO) begin
                    m_busy = 0;
                    if (bus.wb_err) m_new[0] = 1'b1;
                    else if (!bus.wb_ack) m_new[1] = 1'b1;
                    if (!m_we) begin
                        m_rvalid = 1;
                        m_rdata = (bus.wb_ack && !bus.wb_err) ? bus.wb_dat_r : 32'h0;
                    end
                end
            end
            m_err = (bus.err_clr ? 2'b00 : m_err) | m_new;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", 64'(bus.sram_ready), 64'(!m_busy));
            chk("cyc", 64'(bus.wb_cyc), 64'(m_busy));
            chk("stb", 64'(bus.wb_stb), 64'(m_busy));
            chk("read_valid", 64'(bus.sram_read_valid), 64'(m_rvalid));
            chk("read_data", 64'(bus.sram_read_data), 64'(m_rdata));
            chk("err_status", 64'(bus.err_status), 64'(m_err));
            if (m_busy) begin
                chk("wb_adr", 64'(bus.wb_adr), 64'(m_adr));
                chk("wb_sel", 64'(bus.wb_sel), 64'(m_sel));
                chk("wb_we", 64'(bus.wb_we), 64'(m_we));
                if (m_we) chk("wb_dat_w", 64'(bus.wb_dat_w), 64'(m_dat));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in;
        bus.sram_read_en = 0; bus.sram_write_en = 0; bus.sram_byte_en = 4'h0;
        bus.sram_addr = '0; bus.sram_write_data = '0;
        bus.wb_ack = 0; bus.wb_err = 0; bus.wb_dat_r = '0; bus.err_clr = 0;
    endtask

    task automatic req(input bit re, input bit we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.sram_read_en = re; bus.sram_write_en = we; bus.sram_addr = a;
        bus.sram_byte_en = s; bus.sram_write_data = d;
    endtask

    initial begin
        idle_in();
        repeat (2) tick();
        rst = 0;
        tick();
        chk("rst ready", 64'(bus.sram_ready), 64'd1);
        chk("rst cyc", 64'(bus.wb_cyc), 64'd0);
        chk("rst adr", 64'(bus.wb_adr), 64'd0);
        chk("rst err", 64'(bus.err_status), 64'd0);

        // read with single-cycle ack
        req(1, 0, 32'h100, 4'hF, 32'h0);
        tick();
        chk("rd cyc", 64'(bus.wb_cyc), 64'd1);
        chk("rd adr", 64'(bus.wb_adr), 64'h100);
        chk("rd ready", 64'(bus.sram_ready), 64'd0);
        idle_in();
        bus.wb_ack = 1; bus.wb_dat_r = 32'hDEADBEEF;
        tick();
        chk("rd valid", 64'(bus.sram_read_valid), 64'd1);
        chk("rd data", 64'(bus.sram_read_data), 64'hDEADBEEF);
        chk("rd ready2", 64'(bus.sram_ready), 64'd1);
        chk("rd err", 64'(bus.err_status), 64'd0);
        idle_in();
        tick();
        chk("rd valid drop", 64'(bus.sram_read_valid), 64'd0);

        // write held for two unacknowledged cycles
        req(0, 1, 32'h40, 4'h3, 32'h1234);
        tick();
        idle_in();
        chk("wr we", 64'(bus.wb_we), 64'd1);
        chk("wr sel", 64'(bus.wb_sel), 64'h3);
        chk("wr dat", 64'(bus.wb_dat_w), 64'h1234);
        tick();
        chk("wr hold", 64'(bus.wb_dat_w), 64'h1234);
        bus.wb_ack = 1;
        tick();
        idle_in();
        chk("wr cyc", 64'(bus.wb_cyc), 64'd0);
        chk("wr ready", 64'(bus.sram_ready), 64'd1);
        chk("wr no valid", 64'(bus.sram_read_valid), 64'd0);
        chk("wr rdata kept", 64'(bus.sram_read_data), 64'hDEADBEEF);

        // err and ack together
        req(1, 0, 32'h8, 4'hF, 32'h0);
        tick();
        idle_in();
        bus.wb_ack = 1; bus.wb_err = 1; bus.wb_dat_r = 32'h55AA55AA;
        tick();
        idle_in();
        chk("err valid", 64'(bus.sram_read_valid), 64'd1);
        chk("err data", 64'(bus.sram_read_data), 64'd0);
        chk("err flag", 64'(bus.err_status), 64'b01);
        bus.err_clr = 1;
        tick();
        idle_in();
        chk("err clr", 64'(bus.err_status), 64'b00);

        // silent slave forces timeout after TO bus cycles
        req(1, 0, 32'hC, 4'h1, 32'h0);
        tick();
        idle_in();
        repeat (TO - 1) tick();
        chk("tmo cyc last", 64'(bus.wb_cyc), 64'd1);
        tick();
        chk("tmo cyc", 64'(bus.wb_cyc), 64'd0);
        chk("tmo flag", 64'(bus.err_status), 64'b10);
        chk("tmo valid", 64'(bus.sram_read_valid), 64'd1);
        chk("tmo data", 64'(bus.sram_read_data), 64'd0);
        bus.err_clr = 1;
        tick();
        idle_in();

        // ignored requests
        req(1, 1, 32'h20, 4'hF, 32'h1);
        tick();
        chk("both cyc", 64'(bus.wb_cyc), 64'd0);
        chk("both ready", 64'(bus.sram_ready), 64'd1);
        req(1, 0, 32'h20, 4'h0, 32'h1);
        tick();
        idle_in();
        chk("sel0 cyc", 64'(bus.wb_cyc), 64'd0);
        chk("sel0 err", 64'(bus.err_status), 64'd0);

        // reset in the middle of a bus cycle
        req(1, 0, 32'h30, 4'hF, 32'h0);
        tick();
        idle_in();
        bus.wb_ack = 1; bus.wb_dat_r = 32'hCAFEF00D;
        tick();
        idle_in();
        chk("pre-rst data", 64'(bus.sram_read_data), 64'hCAFEF00D);
        req(0, 1, 32'h34, 4'hF, 32'h9);
        tick();
        idle_in();
        rst = 1;
        #1;
        chk("arst cyc", 64'(bus.wb_cyc), 64'd0);
        chk("arst stb", 64'(bus.wb_stb), 64'd0);
        chk("arst we", 64'(bus.wb_we), 64'd0);
        chk("arst adr", 64'(bus.wb_adr), 64'd0);
        chk("arst dat_w", 64'(bus.wb_dat_w), 64'd0);
        chk("arst data", 64'(bus.sram_read_data), 64'd0);
        rst = 0;
        bus.wb_ack = 1;
        tick();
        idle_in();
        chk("post-rst valid", 64'(bus.sram_read_valid), 64'd0);
        chk("post-rst ready", 64'(bus.sram_ready), 64'd1);

        // randomized traffic with random slave behaviour
        for (int i = 0; i < 600; i++) begin
            bus.sram_read_en = $urandom_range(0, 2) == 0;
            bus.sram_write_en = $urandom_range(0, 2) == 0;
            bus.sram_byte_en = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            bus.sram_addr = $urandom;
            bus.sram_write_data = $urandom;
            bus.wb_ack = $urandom_range(0, 3) == 0;
            bus.wb_err = $urandom_range(0, 15) == 0;
            bus.wb_dat_r = $urandom;
            bus.err_clr = $urandom_range(0, 19) == 0;
            if (i % 150 == 75) begin
                #1 rst = 1;
                #1 rst = 0;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_wb_master_bridge.md
SRAM_WB_MASTER_BRIDGE -- requirements
Module: sram_wb_master_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the SRAM-side and Wishbone address.
REQ-002 Parameter DATA_WIDTH, default 32: data width; byte lanes = DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 256: maximum cycles a Wishbone cycle may stay open before abort; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 sram_addr  in  ADDR_WIDTH  request address.
REQ-007 sram_read_en, sram_write_en  in  1 each  request strobes, sampled only while sram_ready=1.
REQ-008 sram_byte_en  in  DATA_WIDTH/8  byte lanes; driven to wb_sel.
REQ-009 sram_write_data  in  DATA_WIDTH  write data.
REQ-010 sram_ready  out  1  bridge can accept a request this cycle.
REQ-011 sram_read_data  out  DATA_WIDTH  read result; held until the next read completes.
REQ-012 sram_read_valid  out  1  one-cycle pulse when sram_read_data is updated.
REQ-013 wb_adr, wb_dat_w, wb_sel, wb_we, wb_cyc, wb_stb  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  Wishbone classic master outputs, all registered.
REQ-014 wb_dat_r, wb_ack, wb_err  in  DATA_WIDTH/1/1  Wishbone slave responses.
REQ-015 err_status  out  2  sticky flags: bit0 bus error (wb_err), bit1 timeout.
REQ-016 err_clr  in  1  clears err_status; a new error in the same cycle takes priority.

Function
REQ-017 States: IDLE, BUS; sram_ready=1 only in IDLE.
REQ-018 IDLE, sram_read_en xor sram_write_en, sram_byte_en!=0: register addr/sel/data/we, assert wb_cyc=wb_stb=1 next cycle, enter BUS.
REQ-019 IDLE, byte_en==0 or both strobes high: request ignored, no bus cycle, no read_valid; stay IDLE.
REQ-020 BUS: Wishbone outputs held constant until termination; timeout counter increments every BUS cycle.
REQ-021 wb_ack sampled high in BUS: drop cyc/stb next cycle, return to IDLE (sram_ready=1 next cycle); if read, sram_read_data<=wb_dat_r and sram_read_valid=1 in that next cycle.
REQ-022 wb_err sampled high in BUS (ack ignored when both): terminate as REQ-021, set err_status[0]; if read, sram_read_data<=0 and read_valid pulses.
REQ-023 Counter reaching TIMEOUT without ack/err: terminate as REQ-021, set err_status[1]; if read, read_data<=0 and read_valid pulses.
REQ-024 Minimum latency: request at cycle N, stb at N+1, ack at N+1 -> read_valid and sram_ready at N+2; back-to-back requests every 2 cycles.
REQ-025 Write completion produces no read_valid; sram_read_data unchanged by writes.
REQ-026 Counter is 16 bits, cleared on entry to BUS; never wraps.

Reset
REQ-027 rst=1 asynchronously forces IDLE, wb_cyc=wb_stb=wb_we=0, wb_adr=wb_dat_w=wb_sel=0, sram_read_data=0, sram_read_valid=0, err_status=0, counter=0; sram_ready=1 after release.
REQ-028 Reset during BUS aborts the cycle immediately (cyc drops asynchronously); no read_valid is generated for the aborted request.

Structure
REQ-029 Package wb_sram_bridge_pkg holds the state enum and ERR_BUS/ERR_TIMEOUT bit-index constants.
REQ-030 One sub-module wb_timeout_counter (clear, enable, TIMEOUT compare, expired output).

Verification
REQ-031 Read addr 0x100, sel 0xF, slave acks 1 cycle after stb with 0xDEADBEEF -> read_valid 2 cycles after request, read_data 0xDEADBEEF, err_status 0.
REQ-032 Write addr 0x40, sel 0x3, data 0x1234 -> wb_we=1, wb_sel=0x3, wb_dat_w 0x1234 held until ack; no read_valid; ready returns next cycle.
REQ-033 Read with slave asserting wb_err and wb_ack together -> read_data 0, read_valid pulse, err_status 0b01; err_clr -> 0b00.
REQ-034 TIMEOUT=8, slave never responds -> cyc drops after 8 BUS cycles, err_status 0b10, read_valid with data 0.
REQ-035 Both strobes high, and byte_en=0 request -> no wb_cyc, ready stays 1, no error flag.
REQ-036 rst asserted mid-BUS -> wb_cyc 0 same cycle, no read_valid, all outputs at reset values.
